// File: rtl/sqrt_iter.sv
// Sequential integer square root: one root bit per clock after a leading-pair seed,
// with valid/ready handshakes on the operand and result sides.
module sqrt_iter #(
  parameter int unsigned WIDTH = 20,
  parameter int unsigned ROUND = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     val_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH/2:0]     root,
  output logic [WIDTH/2:0]     rem,
  output logic                 busy
);

  localparam int unsigned N      = WIDTH / 2;
  localparam int unsigned ROOT_W = N + 1;
  localparam int unsigned REM_W  = N + 1;
  localparam int unsigned T_W    = N + 2;
  localparam int unsigned IDX_W  = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEED = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    op_q, op_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N-1:0]        acc_q, acc_d;
  logic [REM_W-1:0]    prem_q, prem_d;
  logic [ROOT_W-1:0]   root_q, root_d;
  logic [REM_W-1:0]    rem_q, rem_d;
  logic                rdy_q, vld_q, busy_q;

  logic [IDX_W-1:0]    seed_k_c;
  logic                seed_nz_c;
  logic [1:0]          pair_c;
  logic [T_W-1:0]      trial_c, tst_c, diff_c;
  logic                ge_c;
  logic [REM_W-1:0]    rem_nxt_c;
  logic [N-1:0]        acc_nxt_c;
  logic                round_up_c;
  logic [ROOT_W-1:0]   root_fin_c;

  // Highest nonzero bit pair of the captured operand; later pairs win.
  always_comb begin
    seed_k_c  = '0;
    seed_nz_c = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (op_q[2*i +: 2] != 2'b00) begin
        seed_k_c  = IDX_W'(i);
        seed_nz_c = 1'b1;
      end
    end
  end

  // One restoring step; the partial remainder never exceeds twice the partial root.
  always_comb begin
    pair_c     = 2'(op_q >> {idx_q, 1'b0});
    trial_c    = T_W'({prem_q, pair_c});
    tst_c      = {acc_q, 2'b01};
    ge_c       = (trial_c >= tst_c);
    diff_c     = trial_c - tst_c;
    rem_nxt_c  = ge_c ? REM_W'(diff_c) : REM_W'(trial_c);
    acc_nxt_c  = {acc_q[N-2:0], ge_c};
    round_up_c = (ROUND != 0) && (rem_nxt_c > {1'b0, acc_nxt_c});
    root_fin_c = {1'b0, acc_nxt_c} + ROOT_W'(round_up_c);
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    prem_d  = prem_q;
    root_d  = root_q;
    rem_d   = rem_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = val_in;
          acc_d   = '0;
          prem_d  = '0;
          state_d = S_SEED;
        end
      end
      S_SEED: begin
        if (!seed_nz_c) begin
          root_d  = '0;
          rem_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d   = seed_k_c;
          state_d = S_ITER;
        end
      end
      S_ITER: begin
        acc_d  = acc_nxt_c;
        prem_d = rem_nxt_c;
        if (idx_q == '0) begin
          root_d  = root_fin_c;
          rem_d   = rem_nxt_c;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q - IDX_W'(1);
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      idx_q   <= '0;
      acc_q   <= '0;
      prem_q  <= '0;
      root_q  <= '0;
      rem_q   <= '0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      prem_q  <= prem_d;
      root_q  <= root_d;
      rem_q   <= rem_d;
      rdy_q   <= (state_d == S_IDLE);
      vld_q   <= (state_d == S_DONE);
      busy_q  <= (state_d == S_SEED) || (state_d == S_ITER);
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign busy      = busy_q;
  assign root      = root_q;
  assign rem       = rem_q;

endmodule

// File: tb/tb_sqrt_iter.sv
// Bench for sqrt_iter: directed cases on WIDTH=20, then random operands
// on six width/rounding variants checked against an arithmetic square-root model.
module tb_sqrt_iter;

  localparam int DW [6] = '{20, 20, 8, 8, 32, 32};
  localparam int DR [6] = '{0, 1, 0, 1, 0, 1};

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] vin;
  logic [5:0]  iv, ir, ov, bz;
  logic        out_ready;

  logic [10:0] root0, rem0, root1, rem1;
  logic [4:0]  root2, rem2, root3, rem3;
  logic [16:0] root4, rem4, root5, rem5;
  longint      rt [6];
  longint      rm [6];

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sqrt_iter #(.WIDTH(20), .ROUND(0)) u_dut (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .val_in(vin[19:0]),
    .out_valid(ov[0]), .out_ready(out_ready), .root(root0), .rem(rem0), .busy(bz[0]));
  sqrt_iter #(.WIDTH(20), .ROUND(1)) u_dut_r (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .val_in(vin[19:0]),
    .out_valid(ov[1]), .out_ready(out_ready), .root(root1), .rem(rem1), .busy(bz[1]));
  sqrt_iter #(.WIDTH(8), .ROUND(0)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .val_in(vin[7:0]),
    .out_valid(ov[2]), .out_ready(out_ready), .root(root2), .rem(rem2), .busy(bz[2]));
  sqrt_iter #(.WIDTH(8), .ROUND(1)) u_dut8_r (
    .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .val_in(vin[7:0]),
    .out_valid(ov[3]), .out_ready(out_ready), .root(root3), .rem(rem3), .busy(bz[3]));
  sqrt_iter #(.WIDTH(32), .ROUND(0)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(ir[4]), .val_in(vin),
    .out_valid(ov[4]), .out_ready(out_ready), .root(root4), .rem(rem4), .busy(bz[4]));
  sqrt_iter #(.WIDTH(32), .ROUND(1)) u_dut32_r (
    .clk(clk), .rst(rst), .in_valid(iv[5]), .in_ready(ir[5]), .val_in(vin),
    .out_valid(ov[5]), .out_ready(out_ready), .root(root5), .rem(rem5), .busy(bz[5]));

  always_comb begin
    rt[0] = 64'(root0); rm[0] = 64'(rem0);
    rt[1] = 64'(root1); rm[1] = 64'(rem1);
    rt[2] = 64'(root2); rm[2] = 64'(rem2);
    rt[3] = 64'(root3); rm[3] = 64'(rem3);
    rt[4] = 64'(root4); rm[4] = 64'(rem4);
    rt[5] = 64'(root5); rm[5] = 64'(rem5);
  end

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint ref_floor(input longint x);
    longint lo, hi, mid;
    lo = 0;
    hi = 64'd1 << 17;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= x) lo = mid;
      else hi = mid - 1;
    end
    return lo;
  endfunction

  // Nearest integer root: step up when (r+1)^2 is strictly closer to x than r^2.
  function automatic longint ref_root(input longint x, input int rnd);
    longint r;
    r = ref_floor(x);
    if (rnd != 0 && ((r + 1) * (r + 1) - x) < (x - r * r)) r = r + 1;
    return r;
  endfunction

  function automatic int ref_lat(input longint x);
    int k;
    if (x == 0) return 1;
    k = 0;
    while ((x >> (2 * (k + 1))) != 0) k++;
    return k + 2;
  endfunction

  task automatic xact(input int d, input longint x, input longint exp_root,
                      input longint exp_rem, input int hold, input string tag);
    int cyc, lat, bad_busy, unstable;
    lat = ref_lat(x);
    @(negedge clk);
    check_val({tag, "_inrdy"}, 64'(ir[d]), 1);
    vin = 32'(x);
    iv[d] = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    iv[d] = 1'b0;
    cyc = 0;
    bad_busy = 0;
    while (!ov[d] && cyc < 64) begin
      if (bz[d] !== 1'b1) bad_busy++;
      @(negedge clk);
      cyc++;
    end
    check_val({tag, "_lat"}, cyc, lat);
    check_val({tag, "_busy_run"}, bad_busy, 0);
    check_val({tag, "_busy_done"}, 64'(bz[d]), 0);
    check_val({tag, "_root"}, rt[d], exp_root);
    check_val({tag, "_rem"}, rm[d], exp_rem);
    unstable = 0;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      if (ov[d] !== 1'b1 || ir[d] !== 1'b0 || rt[d] != exp_root || rm[d] != exp_rem)
        unstable++;
    end
    if (hold > 0) check_val({tag, "_hold"}, unstable, 0);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_val({tag, "_ov_clr"}, 64'(ov[d]), 0);
    check_val({tag, "_rdy_back"}, 64'(ir[d]), 1);
    check_val({tag, "_root_kept"}, rt[d], exp_root);
  endtask

  initial begin
    longint ops [4];
    longint er  [4];
    longint em  [4];
    int acc_n, got_n, cyc, extra;
    longint x;

    rst = 1'b1;
    iv = '0;
    out_ready = 1'b0;
    vin = '0;
    repeat (2) @(negedge clk);
    check_val("rst_inrdy", 64'(ir[0]), 1);
    check_val("rst_ov", 64'(ov[0]), 0);
    check_val("rst_busy", 64'(bz[0]), 0);
    check_val("rst_root", rt[0], 0);
    check_val("rst_rem", rm[0], 0);
    rst = 1'b0;

    xact(0, 0, 0, 0, 0, "zero");
    xact(0, 80, 8, 16, 0, "v80");
    xact(0, 1048575, 1023, 2046, 0, "max_floor");
    xact(1, 1048575, 1024, 2046, 0, "max_round");
    xact(1, 72, 8, 8, 0, "r72");
    xact(1, 73, 9, 9, 0, "r73");
    xact(0, 144, 12, 0, 10, "bp144");

    // Reset during the third ITER cycle of a long operand.
    @(negedge clk);
    vin = 32'd1048575;
    iv[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    iv[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_val("midrst_inrdy", 64'(ir[0]), 1);
    check_val("midrst_ov", 64'(ov[0]), 0);
    check_val("midrst_root", rt[0], 0);
    check_val("midrst_rem", rm[0], 0);
    @(negedge clk);
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    check_val("midrst_stale", extra, 0);
    xact(0, 4, 2, 0, 0, "after_rst");

    // Back-to-back with both handshakes held high.
    ops = '{1, 2, 3, 99999};
    er  = '{1, 1, 1, 316};
    em  = '{0, 1, 2, 143};
    acc_n = 0;
    got_n = 0;
    cyc = 0;
    out_ready = 1'b1;
    while (got_n < 4 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (ov[0]) begin
        check_val($sformatf("b2b_root%0d", got_n), rt[0], er[got_n]);
        check_val($sformatf("b2b_rem%0d", got_n), rm[0], em[got_n]);
        got_n++;
      end
      if (acc_n < 4) begin
        vin = 32'(ops[acc_n]);
        iv[0] = 1'b1;
        if (ir[0]) acc_n++;
      end else begin
        iv[0] = 1'b0;
      end
    end
    iv[0] = 1'b0;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (ov[0]) extra++;
    end
    check_val("b2b_results", got_n, 4);
    check_val("b2b_accepts", acc_n, 4);
    check_val("b2b_extra", extra, 0);
    out_ready = 1'b0;

    // Random operands, biased toward small values by a random right shift.
    for (int it = 0; it < 1500; it++) begin
      @(negedge clk);
      vin = $urandom >> $urandom_range(0, 31);
      iv = 6'h3F;
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      iv = '0;
      cyc = 0;
      while (ov != 6'h3F && cyc < 64) begin
        @(negedge clk);
        cyc++;
      end
      for (int d = 0; d < 6; d++) begin
        x = longint'(vin) & ((64'd1 << DW[d]) - 1);
        check_val($sformatf("rnd_root_d%0d_x%0d", d, x), rt[d], ref_root(x, DR[d]));
        check_val($sformatf("rnd_rem_d%0d_x%0d", d, x), rm[d], x - ref_floor(x) * ref_floor(x));
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check_val("rnd_drain", 64'(ov), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
